// File: rtl/mdu_ctrl_pkg.sv
// Shared ALU control codes, MDU state encodings and decode helpers for the multiply/divide unit.
package mdu_ctrl_pkg;

    localparam logic [4:0] AND_CONTROL   = 5'b00000;
    localparam logic [4:0] OR_CONTROL    = 5'b00001;
    localparam logic [4:0] ADD_CONTROL   = 5'b00010;
    localparam logic [4:0] SUB_CONTROL   = 5'b00110;
    localparam logic [4:0] SLT_CONTROL   = 5'b00111;
    localparam logic [4:0] DIV_CONTROL   = 5'b10000;
    localparam logic [4:0] DIVU_CONTROL  = 5'b10001;
    localparam logic [4:0] MULT_CONTROL  = 5'b10010;
    localparam logic [4:0] MULTU_CONTROL = 5'b10011;

    localparam int DIV_ITER = 32;

    typedef enum logic [1:0] {
        MDU_IDLE = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2
    } mdu_state_e;

    function automatic logic is_div_op(input logic [4:0] code);
        return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
    endfunction

    function automatic logic is_mul_op(input logic [4:0] code);
        return (code == MULT_CONTROL) || (code == MULTU_CONTROL);
    endfunction

endpackage

// File: rtl/mdu_ctrl_div_step.sv
// One restoring-division iteration (the div_step stage): shift rem:dividend left, trial-subtract divisor.
// Latency: combinational. Backpressure: none, the caller sequences iterations.
module mdu_ctrl_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem,
    input  logic [W-1:0] shift,
    input  logic [W-1:0] divisor,
    output logic [W-1:0] rem_next,
    output logic [W-1:0] shift_next,
    output logic         q_bit
);

    logic [W:0] rem_sh;
    logic [W:0] trial;

    // One extra bit so a divisor with its MSB set cannot overflow the trial subtract.
    assign rem_sh     = {rem, shift[W-1]};
    assign trial      = rem_sh - {1'b0, divisor};
    assign q_bit      = ~trial[W];
    assign rem_next   = q_bit ? trial[W-1:0] : rem_sh[W-1:0];
    assign shift_next = {shift[W-2:0], 1'b0};

endmodule

// File: rtl/mdu_ctrl.sv
// Execute-stage multiply/divide sequencer producing HI/LO values and the write strobe.
// Latency: MULT/MULTU same cycle; DIV/DIVU hold E for 33 cycles, result in the 34th.
// Backpressure: stall_ext holds a finished divide in DONE; flush_e abandons any operation.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int DATA_W = DIV_ITER
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        alucontrol_e,
    input  logic [DATA_W-1:0] a_e,
    input  logic [DATA_W-1:0] b_e,
    input  logic              flush_e,
    input  logic              stall_ext,
    output logic              stall_e,
    output logic              hilo_we,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_busy
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    mdu_state_e state_q, state_d;

    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   rem_q, shift_q, divisor_q, quo_q;
    logic                qneg_q, rneg_q;

    logic                is_div, is_mul, is_signed, start;
    logic [DATA_W-1:0]   a_abs, b_abs;
    logic [DATA_W-1:0]   rem_step, shift_step;
    logic                q_step;
    logic [2*DATA_W-1:0] product;
    logic [DATA_W-1:0]   hi_fix, lo_fix;

    assign is_div    = is_div_op(alucontrol_e);
    assign is_mul    = is_mul_op(alucontrol_e);
    assign is_signed = (alucontrol_e == DIV_CONTROL);
    assign start     = (state_q == MDU_IDLE) && is_div && !flush_e;

    assign a_abs = a_e[DATA_W-1] ? -a_e : a_e;
    assign b_abs = b_e[DATA_W-1] ? -b_e : b_e;

    always_comb begin
        product = '0;
        if (alucontrol_e == MULT_CONTROL) begin
            product = $signed({{DATA_W{a_e[DATA_W-1]}}, a_e})
                    * $signed({{DATA_W{b_e[DATA_W-1]}}, b_e});
        end else begin
            product = {{DATA_W{1'b0}}, a_e} * {{DATA_W{1'b0}}, b_e};
        end
    end

    mdu_ctrl_div_step #(.W(DATA_W)) u_div_step (
        .rem        (rem_q),
        .shift      (shift_q),
        .divisor    (divisor_q),
        .rem_next   (rem_step),
        .shift_next (shift_step),
        .q_bit      (q_step)
    );

    assign lo_fix = qneg_q ? -quo_q : quo_q;
    assign hi_fix = rneg_q ? -rem_q : rem_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            shift_q   <= '0;
            divisor_q <= '0;
            quo_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start) begin
                shift_q   <= is_signed ? a_abs : a_e;
                divisor_q <= is_signed ? b_abs : b_e;
                rem_q     <= '0;
                quo_q     <= '0;
                cnt_q     <= '0;
                qneg_q    <= is_signed && (a_e[DATA_W-1] ^ b_e[DATA_W-1]);
                rneg_q    <= is_signed && a_e[DATA_W-1];
            end else if ((state_q == MDU_BUSY) && !flush_e) begin
                rem_q   <= rem_step;
                shift_q <= shift_step;
                quo_q   <= {quo_q[DATA_W-2:0], q_step};
                cnt_q   <= cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        stall_e  = 1'b0;
        hilo_we  = 1'b0;
        hi_o     = '0;
        lo_o     = '0;
        div_busy = 1'b0;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    stall_e  = 1'b1;
                    div_busy = 1'b1;
                    state_d  = MDU_BUSY;
                end else if (is_mul) begin
                    hi_o    = product[2*DATA_W-1:DATA_W];
                    lo_o    = product[DATA_W-1:0];
                    hilo_we = !flush_e && !stall_ext;
                end
            end
            MDU_BUSY: begin
                div_busy = 1'b1;
                if (flush_e) begin
                    state_d = MDU_IDLE;
                end else begin
                    stall_e = 1'b1;
                    if (cnt_q == CNT_LAST) begin
                        state_d = MDU_DONE;
                    end
                end
            end
            MDU_DONE: begin
                div_busy = 1'b1;
                hi_o     = hi_fix;
                lo_o     = lo_fix;
                if (flush_e) begin
                    state_d = MDU_IDLE;
                end else if (!stall_ext) begin
                    hilo_we = 1'b1;
                    state_d = MDU_IDLE;
                end
            end
            default: state_d = MDU_IDLE;
        endcase
        // Reset forces every output low even where the terms above are combinational.
        if (rst) begin
            stall_e  = 1'b0;
            hilo_we  = 1'b0;
            hi_o     = '0;
            lo_o     = '0;
            div_busy = 1'b0;
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: vector table plus hand sequences, HI/LO writes scored from a queue.
module tb_mdu_ctrl;
    import mdu_ctrl_pkg::*;

    localparam logic [4:0] NOP = ADD_CONTROL;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  alucontrol_e;
    logic [31:0] a_e, b_e;
    logic        flush_e, stall_ext;
    logic        stall_e, hilo_we, div_busy;
    logic [31:0] hi_o, lo_o;

    int n_chk  = 0;
    int n_fail = 0;
    logic [63:0] sb[$];

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[12];

    mdu_ctrl #(.DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .alucontrol_e (alucontrol_e),
        .a_e          (a_e),
        .b_e          (b_e),
        .flush_e      (flush_e),
        .stall_ext    (stall_ext),
        .stall_e      (stall_e),
        .hilo_we      (hilo_we),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .div_busy     (div_busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: every HI/LO write must match the oldest pending expectation.
    always @(negedge clk) begin
        if (!rst && hilo_we) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_hilo_we: got hi=%h lo=%h with nothing pending", hi_o, lo_o);
            end else begin
                chk("hilo_result", {hi_o, lo_o}, sb.pop_front());
            end
        end
    end

    task automatic run_mul(input vec_t v);
        @(posedge clk); #1;
        alucontrol_e = v.op; a_e = v.a; b_e = v.b;
        sb.push_back({v.hi, v.lo});
        @(negedge clk);
        chk("mul_stall_e", 64'(stall_e), 64'd0);
        chk("mul_hilo_we", 64'(hilo_we), 64'd1);
    endtask

    task automatic run_div(input vec_t v, input int hold);
        int stalls = 0;
        int cyc = 0;
        int hold_left = hold;
        bit done = 0;
        @(posedge clk); #1;
        alucontrol_e = v.op; a_e = v.a; b_e = v.b;
        stall_ext = (hold > 0);
        sb.push_back({v.hi, v.lo});
        while (!done && cyc < 80) begin
            @(negedge clk);
            cyc++;
            if (stall_e) begin
                stalls++;
            end else if (div_busy && !hilo_we) begin
                chk("done_held_we", 64'(hilo_we), 64'd0);
                chk("done_held_val", {hi_o, lo_o}, {v.hi, v.lo});
                hold_left--;
                if (hold_left <= 0) begin
                    @(posedge clk); #1;
                    stall_ext = 1'b0;
                end
            end else if (hilo_we) begin
                done = 1;
            end
        end
        if (!done) begin
            n_chk++;
            n_fail++;
            $display("FAIL div_timeout: got no hilo_we after %0d cycles, required one", cyc);
        end
        chk("div_stall_cycles", 64'(stalls), 64'd33);
        chk("div_occupancy", 64'(cyc), 64'(34 + hold));
        @(posedge clk); #1;
        alucontrol_e = NOP;
        stall_ext = 1'b0;
        @(negedge clk);
        chk("div_released", {62'd0, div_busy, stall_e}, 64'd0);
    endtask

    initial begin
        vecs[0]  = '{MULT_CONTROL,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE};
        vecs[1]  = '{MULTU_CONTROL, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE};
        vecs[2]  = '{MULT_CONTROL,  32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[3]  = '{MULTU_CONTROL, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
        vecs[4]  = '{MULT_CONTROL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[5]  = '{DIVU_CONTROL,  32'd100,      32'd7,        32'd2,        32'd14};
        vecs[6]  = '{DIV_CONTROL,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[7]  = '{DIVU_CONTROL,  32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[8]  = '{DIV_CONTROL,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
        vecs[9]  = '{DIV_CONTROL,   32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'h00000001};
        vecs[10] = '{DIVU_CONTROL,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[11] = '{DIV_CONTROL,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};

        rst = 1'b1; alucontrol_e = MULT_CONTROL; a_e = 32'hFFFFFFFF; b_e = 32'd2;
        flush_e = 1'b0; stall_ext = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs_mul", {hi_o, lo_o}, 64'd0);
        chk("reset_ctrl_mul", {61'd0, stall_e, hilo_we, div_busy}, 64'd0);
        alucontrol_e = DIVU_CONTROL;
        #1;
        chk("reset_ctrl_div", {61'd0, stall_e, hilo_we, div_busy}, 64'd0);
        @(posedge clk); #1;
        alucontrol_e = NOP; rst = 1'b0;

        // Codes outside the MDU set leave every output low.
        a_e = 32'd5; b_e = 32'd3;
        @(negedge clk);
        chk("nop_outputs", {hi_o, lo_o}, 64'd0);
        chk("nop_ctrl", {61'd0, stall_e, hilo_we, div_busy}, 64'd0);

        for (int i = 0; i < 12; i++) begin
            if (is_mul_op(vecs[i].op)) run_mul(vecs[i]);
            else                       run_div(vecs[i], 0);
        end
        @(posedge clk); #1;
        alucontrol_e = NOP;

        // Multiply suppressed by flush and by a downstream stall.
        @(posedge clk); #1;
        alucontrol_e = MULT_CONTROL; a_e = 32'd3; b_e = 32'd4; flush_e = 1'b1;
        @(negedge clk);
        chk("mul_flush_we", {62'd0, hilo_we, stall_e}, 64'd0);
        @(posedge clk); #1;
        flush_e = 1'b0; stall_ext = 1'b1;
        @(negedge clk);
        chk("mul_stall_we", {62'd0, hilo_we, stall_e}, 64'd0);
        chk("mul_stall_val", {hi_o, lo_o}, 64'd12);
        @(posedge clk); #1;
        stall_ext = 1'b0;

        // Divide request arriving with a flush never starts.
        alucontrol_e = DIVU_CONTROL; a_e = 32'd100; b_e = 32'd7; flush_e = 1'b1;
        @(negedge clk);
        chk("div_flush_idle", {62'd0, stall_e, div_busy}, 64'd0);
        @(posedge clk); #1;
        flush_e = 1'b0; alucontrol_e = NOP;
        @(negedge clk);
        chk("div_flush_nostart", {62'd0, stall_e, div_busy}, 64'd0);

        // Finished divide held in DONE by a downstream stall for three cycles.
        run_div('{DIVU_CONTROL, 32'd100, 32'd7, 32'd2, 32'd14}, 3);

        // Flush at BUSY counter=10 abandons the divide with no write.
        @(posedge clk); #1;
        alucontrol_e = DIVU_CONTROL; a_e = 32'd100; b_e = 32'd7;
        repeat (11) @(posedge clk);
        #1 flush_e = 1'b1;
        @(negedge clk);
        chk("busy_flush_cycle", {62'd0, stall_e, hilo_we}, 64'd0);
        @(posedge clk); #1;
        flush_e = 1'b0; alucontrol_e = NOP;
        @(negedge clk);
        chk("busy_flush_after", {62'd0, stall_e, div_busy}, 64'd0);
        repeat (40) @(posedge clk);

        // Reset at BUSY counter=20 clears outputs immediately.
        #1;
        alucontrol_e = DIVU_CONTROL; a_e = 32'd5; b_e = 32'd0;
        repeat (21) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midreset_outputs", {hi_o, lo_o}, 64'd0);
        chk("midreset_ctrl", {61'd0, stall_e, hilo_we, div_busy}, 64'd0);
        alucontrol_e = NOP;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_idle", {62'd0, stall_e, div_busy}, 64'd0);
        repeat (40) @(posedge clk);

        run_div('{DIVU_CONTROL, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF}, 0);

        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
